// File: rtl/ap_prof_pkg.sv
// ap_prof_pkg: shared record layout, FSM states and the incomplete-latency marker
package ap_prof_pkg;
  localparam int PROF_ID_W = 16;
  localparam int PROF_TS_W = 32;
  localparam logic [PROF_TS_W-1:0] LAT_INCOMPLETE = '1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} prof_state_e;
  typedef struct packed {
    logic [PROF_ID_W-1:0] id;
    logic [PROF_TS_W-1:0] start_ts;
    logic [PROF_TS_W-1:0] latency;
    logic [PROF_TS_W-1:0] interval;
    logic [PROF_TS_W-1:0] stall;
  } prof_rec_t;
endpackage

// File: rtl/prof_sync_fifo.sv
// prof_sync_fifo: count-based synchronous FIFO; a full FIFO still takes a push when popped in the same cycle
module prof_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_q];
  always_ff @(posedge clock_i)
    if (do_push) mem_q[wr_q] <= din_i;
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(do_push);
      rd_q  <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/ap_ctrl_txn_profiler.sv
// ap_ctrl_txn_profiler: per-invocation latency/interval/stall records from an ap_ctrl handshake
// PROFILER_STALL_EN adds the stall counter and its record storage; otherwise rec_stall is 0.
module ap_ctrl_txn_profiler
  import ap_prof_pkg::*;
#(
  parameter int TS_W       = 32,
  parameter int ID_W       = 16,
  parameter int PEND_DEPTH = 4,
  parameter int OUT_DEPTH  = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ap_start,
  input  logic            ap_ready,
  input  logic            ap_done,
  input  logic            ap_continue,
  input  logic            finish,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [ID_W-1:0] rec_id,
  output logic [TS_W-1:0] rec_start_ts,
  output logic [TS_W-1:0] rec_latency,
  output logic [TS_W-1:0] rec_interval,
  output logic [TS_W-1:0] rec_stall,
  output logic [15:0]     drop_cnt,
  output logic            orphan_err,
  output logic            flushed
);
`ifdef PROFILER_STALL_EN
  localparam int SW = TS_W;
`else
  localparam int SW = 0;
`endif
  localparam int HW = ID_W + TS_W;
  localparam int PW = HW + TS_W + SW;
  localparam int OW = PW + TS_W;
  prof_state_e     state_q;
  logic [TS_W-1:0] ts_q, prev_q, interval, lat;
  logic [ID_W-1:0] id_q;
  logic            first_q, rec_vld_q, orphan_q, flushed_q;
  logic            active, st_acc, dn_acc, bypass, drain_pop, pend_drop, out_drop, out_pop;
  logic            pend_full, pend_empty, out_full, out_empty;
  logic [PW-1:0]   pend_din, pend_dout, src;
  logic [OW-1:0]   rec_q, rec_d, out_dout, out_vis;
  logic [15:0]     drop_q;
  logic [16:0]     drop_sum;
  prof_rec_t       out_rec;
  assign active    = (state_q == IDLE) | (state_q == RUN);
  assign st_acc    = active & ap_start & ap_ready;
  assign dn_acc    = active & ap_done & ap_continue;
  assign bypass    = st_acc & dn_acc & pend_empty;
  assign pend_drop = st_acc & ~bypass & pend_full;
  // one drain pop per free slot, never while a record is still staged
  assign drain_pop = (state_q == DRAIN) & ~pend_empty & ~out_full & ~rec_vld_q;
  assign interval  = first_q ? '0 : ts_q - prev_q;
`ifdef PROFILER_STALL_EN
  logic [TS_W-1:0] stall_q;
  assign pend_din = {id_q, ts_q, interval, stall_q};
  always_ff @(posedge clock or posedge reset)
    if (reset) stall_q <= '0;
    else stall_q <= st_acc ? '0 : stall_q + TS_W'(ap_start & ~ap_ready);
`else
  assign pend_din = {id_q, ts_q, interval};
`endif
  prof_sync_fifo #(.W(PW), .DEPTH(PEND_DEPTH)) u_pend (
    .clock_i(clock), .reset_i(reset),
    .push_i(st_acc & ~bypass & ~pend_full), .pop_i((dn_acc & ~pend_empty) | drain_pop),
    .din_i(pend_din), .dout_o(pend_dout), .full_o(pend_full), .empty_o(pend_empty)
  );
  // a bypass record is built from the live start, so its latency is ts - ts = 0
  assign src   = bypass ? pend_din : pend_dout;
  assign lat   = drain_pop ? TS_W'(LAT_INCOMPLETE) : ts_q - src[PW-ID_W-1 -: TS_W];
  assign rec_d = {src[PW-1 -: HW], lat, src[PW-HW-1:0]};
  prof_sync_fifo #(.W(OW), .DEPTH(OUT_DEPTH)) u_out (
    .clock_i(clock), .reset_i(reset),
    .push_i(rec_vld_q), .pop_i(out_pop),
    .din_i(rec_q), .dout_o(out_dout), .full_o(out_full), .empty_o(out_empty)
  );
  assign out_pop  = rec_valid & rec_ready;
  assign out_drop = rec_vld_q & out_full & ~out_pop;
  assign drop_sum = {1'b0, drop_q} + 17'(pend_drop) + 17'(out_drop);
  assign out_vis  = out_empty ? '0 : out_dout;
  always_comb begin
    out_rec          = '0;
    out_rec.id       = PROF_ID_W'(out_vis[OW-1 -: ID_W]);
    out_rec.start_ts = PROF_TS_W'(out_vis[OW-ID_W-1 -: TS_W]);
    out_rec.latency  = PROF_TS_W'(out_vis[OW-HW-1 -: TS_W]);
    out_rec.interval = PROF_TS_W'(out_vis[OW-HW-TS_W-1 -: TS_W]);
`ifdef PROFILER_STALL_EN
    out_rec.stall    = PROF_TS_W'(out_vis[TS_W-1:0]);
`endif
  end
  assign rec_valid    = ~out_empty;
  assign rec_id       = ID_W'(out_rec.id);
  assign rec_start_ts = TS_W'(out_rec.start_ts);
  assign rec_latency  = TS_W'(out_rec.latency);
  assign rec_interval = TS_W'(out_rec.interval);
  assign rec_stall    = TS_W'(out_rec.stall);
  assign drop_cnt     = drop_q;
  assign orphan_err   = orphan_q;
  assign flushed      = flushed_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      ts_q      <= '0;
      id_q      <= '0;
      prev_q    <= '0;
      first_q   <= 1'b1;
      rec_q     <= '0;
      rec_vld_q <= 1'b0;
      drop_q    <= '0;
      orphan_q  <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      ts_q      <= ts_q + TS_W'(1);
      id_q      <= st_acc ? id_q + ID_W'(1) : id_q;
      prev_q    <= st_acc ? ts_q : prev_q;
      first_q   <= first_q & ~st_acc;
      rec_q     <= rec_d;
      rec_vld_q <= (dn_acc & (~pend_empty | st_acc)) | drain_pop;
      drop_q    <= drop_sum[16] ? '1 : drop_sum[15:0];
      orphan_q  <= orphan_q | (dn_acc & pend_empty & ~st_acc);
      case (state_q)
        IDLE:    state_q <= finish ? DRAIN : st_acc ? RUN : IDLE;
        RUN:     state_q <= finish ? DRAIN : RUN;
        DRAIN:   state_q <= pend_empty ? DONE : DRAIN;
        default: flushed_q <= flushed_q | (out_empty & ~rec_vld_q);
      endcase
    end
endmodule

// File: tb/tb_ap_ctrl_txn_profiler.sv
// tb_ap_ctrl_txn_profiler: directed and random handshakes scored against a queue-based transaction model
module tb_ap_ctrl_txn_profiler;
`ifdef PROFILER_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  typedef struct {
    logic [15:0] id;
    logic [31:0] ts;
    logic [31:0] lat;
    logic [31:0] iv;
    logic [31:0] st;
  } rec_t;
  logic clock = 1'b0, reset = 1'b1;
  logic ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b0;
  logic finish = 1'b0, rec_ready = 1'b0;
  logic rec_valid, orphan_err, flushed;
  logic [15:0] rec_id, drop_cnt;
  logic [31:0] rec_start_ts, rec_latency, rec_interval, rec_stall;
  always #5 clock = ~clock;
  ap_ctrl_txn_profiler dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_id(rec_id),
    .rec_start_ts(rec_start_ts), .rec_latency(rec_latency), .rec_interval(rec_interval),
    .rec_stall(rec_stall), .drop_cnt(drop_cnt), .orphan_err(orphan_err), .flushed(flushed)
  );
  int errors = 0, checks = 0;
  rec_t exp_q[$], pend_q[$], got_q[$];
  logic [31:0] mts, mprev, mstall;
  logic [15:0] mid;
  bit mfirst, mactive, morph;
  int mdrop;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    {ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready} = '0;
    @(negedge clock);
    check("rst_valid", rec_valid, 0);
    check("rst_id", rec_id, 0);
    check("rst_start", rec_start_ts, 0);
    check("rst_lat", rec_latency, 0);
    check("rst_iv", rec_interval, 0);
    check("rst_stall", rec_stall, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_orphan", orphan_err, 0);
    check("rst_flushed", flushed, 0);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    pend_q.delete();
    mts = 0; mprev = 0; mstall = 0; mid = 0;
    mfirst = 1; mactive = 1; morph = 0; mdrop = 0;
  endtask
  // one clock cycle: drive, score any transfer, advance the transaction model
  task automatic step(input bit s, input bit r, input bit d, input bit c, input bit fin, input bit rdy);
    rec_t e;
    bit st, dn, pe, full;
    logic [31:0] iv, sv;
    ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = fin; rec_ready = rdy;
    if (rec_valid && rdy) begin
      if (exp_q.size() == 0) check("spurious_rec", rec_valid, 0);
      else begin
        e = exp_q.pop_front();
        check("rec_id", rec_id, e.id);
        check("rec_start_ts", rec_start_ts, e.ts);
        check("rec_latency", rec_latency, e.lat);
        check("rec_interval", rec_interval, e.iv);
        check("rec_stall", rec_stall, e.st);
        got_q.push_back('{rec_id, rec_start_ts, rec_latency, rec_interval, rec_stall});
      end
    end else if (exp_q.size() == 0) check("idle_valid", rec_valid, 0);
    st = mactive && s && r;
    dn = mactive && d && c;
    pe = pend_q.size() == 0;
    full = pend_q.size() == 4;
    iv = mfirst ? 32'd0 : mts - mprev;
    sv = STALL_EN ? mstall : 32'd0;
    if (dn) begin
      if (!pe) begin
        e = pend_q.pop_front();
        e.lat = mts - e.ts;
        exp_q.push_back(e);
      end else if (st) exp_q.push_back('{mid, mts, 32'd0, iv, sv});
      else morph = 1;
    end
    if (st && !(dn && pe)) begin
      if (full) mdrop++;
      else pend_q.push_back('{mid, mts, 32'd0, iv, sv});
    end
    if (st) begin
      mid++; mprev = mts; mfirst = 0; mstall = 0;
    end else if (s && !r) mstall++;
    if (fin && mactive) begin
      mactive = 0;
      while (pend_q.size() != 0) begin
        e = pend_q.pop_front();
        e.lat = 32'hFFFF_FFFF;
        exp_q.push_back(e);
      end
    end
    mts++;
    @(negedge clock);
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 1, 0, 1, 0, 1);
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while (!flushed && n < budget) begin
      step(0, 1, 0, 1, 0, 1);
      n++;
    end
    check("flushed", flushed, 1);
    check("drain_left", exp_q.size(), 0);
  endtask
  initial begin
    bit s, r, d, c;
    do_reset();
    for (int t = 0; t <= 25; t++) step(t == 10, 1, t == 25, 1, 0, 1);
    check("lat_cycle1", rec_valid, 0);
    idle(1);
    check("lat_cycle2", rec_valid, 1);
    idle(3);
    check("single_n", got_q.size(), 1);
    check("single_id", got_q[0].id, 0);
    check("single_start", got_q[0].ts, 10);
    check("single_lat", got_q[0].lat, 15);
    check("single_iv", got_q[0].iv, 0);
    do_reset(); got_q.delete();
    for (int t = 0; t < 34; t++) step(t == 5 || t == 9 || t == 13, 1, t == 20 || t == 24 || t == 28, 1, 0, 1);
    check("b2b_n", got_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check("b2b_id", got_q[k].id, k);
      check("b2b_start", got_q[k].ts, 5 + 4 * k);
      check("b2b_lat", got_q[k].lat, 15);
      check("b2b_iv", got_q[k].iv, k == 0 ? 0 : 4);
    end
    do_reset(); got_q.delete();
    repeat (12) begin
      step(1, 1, 0, 1, 0, 0);
      step(0, 1, 1, 1, 0, 0);
    end
    repeat (4) step(0, 1, 0, 1, 0, 0);
    check("bp_drop", drop_cnt, 4);
    check("bp_valid", rec_valid, 1);
    mdrop += 4;
    repeat (4) void'(exp_q.pop_back());
    idle(14);
    check("bp_delivered", got_q.size(), 8);
    check("bp_last_id", got_q[7].id, 7);
    check("bp_drop_model", drop_cnt, mdrop);
    do_reset(); got_q.delete();
    idle(3);
    step(0, 1, 1, 1, 0, 1);
    idle(4);
    check("orphan", orphan_err, 1);
    check("orphan_norec", got_q.size(), 0);
    do_reset(); got_q.delete();
    step(1, 1, 0, 1, 0, 1);
    idle(2);
    do_reset();
    step(0, 1, 1, 1, 0, 1);
    idle(4);
    check("midrst_norec", got_q.size(), 0);
    check("midrst_orphan", orphan_err, 1);
    do_reset(); got_q.delete();
    step(1, 1, 0, 1, 0, 1);
    idle(1);
    step(1, 1, 0, 1, 0, 1);
    idle(1);
    step(0, 1, 0, 1, 1, 1);
    drain(40);
    check("fin_n", got_q.size(), 2);
    for (int k = 0; k < 2; k++) begin
      check("fin_id", got_q[k].id, k);
      check("fin_lat", got_q[k].lat, 32'hFFFF_FFFF);
    end
    do_reset(); got_q.delete();
    idle(2);
    repeat (7) step(1, 0, 0, 1, 0, 1);
    step(1, 1, 0, 1, 0, 1);
    idle(3);
    step(0, 1, 1, 1, 0, 1);
    idle(4);
    check("stall_n", got_q.size(), 1);
    check("stall_val", got_q[0].st, STALL_EN ? 7 : 0);
    check("stall_lat", got_q[0].lat, 4);
    do_reset(); got_q.delete();
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 2) == 0) && (pend_q.size() < 4);
      r = $urandom_range(0, 3) != 0;
      d = ($urandom_range(0, 2) == 0) && (exp_q.size() < 5);
      c = $urandom_range(0, 3) != 0;
      step(s, r, d, c, 0, $urandom_range(0, 3) != 0);
    end
    step(0, 1, 0, 1, 1, 1);
    drain(80);
    check("rand_drop", drop_cnt, mdrop);
    check("rand_orphan", orphan_err, morph);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
